// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor computing (a - b) mod 2^WIDTH, one bit per
// clock, LSB first, through a single full-subtractor cell and a borrow flop.
//
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start      : request to begin a - b, sampled only while idle
//   a, b       : minuend / subtrahend, captured on an accepted start
//   busy       : high whenever the controller is not idle (registered)
//   done       : one-cycle pulse, result outputs valid
//   diff       : registered result (a - b) mod 2^WIDTH
//   borrow_out : final borrow, 1 iff a < b (unsigned)
//   zero       : 1 iff the latest diff equals 0
//
// Timing: start accepted at edge k -> WIDTH RUN cycles -> results load and
// done rises at edge k+WIDTH -> back to idle at edge k+WIDTH+1, so the next
// start can be accepted at edge k+WIDTH+2.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  // Counter just wide enough to index bit WIDTH-1; it stops there, never wraps.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full-subtractor difference bit.
  function automatic logic fs_diff(input logic ai, input logic bi, input logic bin);
    return ai ^ bi ^ bin;
  endfunction

  // Full-subtractor borrow-out.
  function automatic logic fs_borrow(input logic ai, input logic bi, input logic bin);
    return (~ai & bi) | (~(ai ^ bi) & bin);
  endfunction

  state_t           state_r,  state_s;
  logic [WIDTH-1:0] a_sh_r,   a_sh_s;
  logic [WIDTH-1:0] b_sh_r,   b_sh_s;
  logic [WIDTH-1:0] d_sh_r,   d_sh_s;
  logic             bin_r,    bin_s;
  logic [CW-1:0]    cnt_r,    cnt_s;
  logic             busy_r,   busy_s;
  logic             done_r,   done_s;
  logic [WIDTH-1:0] diff_r,   diff_s;
  logic             borrow_r, borrow_s;
  logic             zero_r,   zero_s;

  logic             d_bit_s;
  logic             bout_s;
  logic [WIDTH-1:0] d_full_s;

  // Subtractor cell always looks at the current LSBs and the stored borrow.
  assign d_bit_s  = fs_diff(a_sh_r[0], b_sh_r[0], bin_r);
  assign bout_s   = fs_borrow(a_sh_r[0], b_sh_r[0], bin_r);
  // Result register after inserting the current bit at the top.
  assign d_full_s = {d_bit_s, d_sh_r[WIDTH-1:1]};

  // Next-state and datapath next values; everything holds unless changed.
  always_comb begin
    state_s  = state_r;
    a_sh_s   = a_sh_r;
    b_sh_s   = b_sh_r;
    d_sh_s   = d_sh_r;
    bin_s    = bin_r;
    cnt_s    = cnt_r;
    done_s   = 1'b0;
    diff_s   = diff_r;
    borrow_s = borrow_r;
    zero_s   = zero_r;
    busy_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          a_sh_s  = a;
          b_sh_s  = b;
          d_sh_s  = {WIDTH{1'b0}};
          bin_s   = 1'b0;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end

      RUN: begin
        a_sh_s = {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_s = {1'b0, b_sh_r[WIDTH-1:1]};
        d_sh_s = d_full_s;
        bin_s  = bout_s;
        if (cnt_r == LAST_BIT) begin
          // Final bit: publish all results on this same edge.
          state_s  = DONE;
          diff_s   = d_full_s;
          borrow_s = bout_s;
          zero_s   = (d_full_s == {WIDTH{1'b0}});
          done_s   = 1'b1;
        end else begin
          state_s = RUN;
          cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // busy is registered from the next state, so it tracks the state register.
    if (state_s != IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; reset clears operands, borrow and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      d_sh_r   <= {WIDTH{1'b0}};
      bin_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      zero_r   <= 1'b1;
    end else begin
      a_sh_r   <= a_sh_s;
      b_sh_r   <= b_sh_s;
      d_sh_r   <= d_sh_s;
      bin_r    <= bin_s;
      cnt_r    <= cnt_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      diff_r   <= diff_s;
      borrow_r <= borrow_s;
      zero_r   <= zero_s;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_r;
  assign zero       = zero_r;

endmodule
